// File: rtl/midi_msg_parser.sv
// MIDI byte-stream to message assembler: running status, real-time interleave,
// SysEx skip and optional channel filter, one-deep valid/ready output slot.
module midi_msg_parser #(
    parameter int unsigned C_CHANNEL      = 0,
    parameter int unsigned C_OMNI         = 1,
    parameter int unsigned C_VEL0_NOTEOFF = 1,
    parameter int unsigned C_PASS_RT      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic [7:0] msg_status,
    output logic [6:0] msg_data1,
    output logic [6:0] msg_data2,
    output logic [1:0] msg_len,
    output logic       msg_valid,
    input  logic       msg_ready
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT_D1 = 2'd1;
    localparam logic [1:0] ST_WAIT_D2 = 2'd2;
    localparam logic [1:0] ST_SYSEX   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] run_status_q, run_status_d;
    logic [6:0] data1_q, data1_d;
    logic       msg_valid_q, msg_valid_d;
    logic [7:0] msg_status_q, msg_status_d;
    logic [6:0] msg_data1_q, msg_data1_d;
    logic [6:0] msg_data2_q, msg_data2_d;
    logic [1:0] msg_len_q, msg_len_d;

    logic       byte_fire;
    logic       chan_ok;
    logic       one_data;
    logic       emit;
    logic [7:0] emit_status;
    logic [6:0] emit_d1;
    logic [6:0] emit_d2;
    logic [1:0] emit_len;

    assign byte_ready = ~msg_valid_q | msg_ready;
    assign byte_fire  = byte_valid & byte_ready;
    assign chan_ok    = (C_OMNI != 0) || (run_status_q[3:0] == 4'(C_CHANNEL));
    assign one_data   = (run_status_q[7:4] == 4'hC) || (run_status_q[7:4] == 4'hD);

    // Byte classification, parser state and output slot update
    always_comb begin
        state_d      = state_q;
        run_status_d = run_status_q;
        data1_d      = data1_q;
        msg_valid_d  = msg_valid_q;
        msg_status_d = msg_status_q;
        msg_data1_d  = msg_data1_q;
        msg_data2_d  = msg_data2_q;
        msg_len_d    = msg_len_q;
        emit         = 1'b0;
        emit_status  = 8'h00;
        emit_d1      = 7'h00;
        emit_d2      = 7'h00;
        emit_len     = 2'd0;

        if (msg_valid_q && msg_ready) begin
            msg_valid_d = 1'b0;
        end

        if (byte_fire) begin
            if (!byte_in[7]) begin
                case (state_q)
                    ST_WAIT_D1: begin
                        if (one_data) begin
                            emit        = chan_ok;
                            emit_status = run_status_q;
                            emit_d1     = byte_in[6:0];
                            emit_len    = 2'd2;
                        end else begin
                            data1_d = byte_in[6:0];
                            state_d = ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: begin
                        emit        = chan_ok;
                        emit_status = run_status_q;
                        emit_d1     = data1_q;
                        emit_d2     = byte_in[6:0];
                        emit_len    = 2'd3;
                        state_d     = ST_WAIT_D1;
                        // Zero-velocity note-on is reported as note-off
                        if ((C_VEL0_NOTEOFF != 0) && (run_status_q[7:4] == 4'h9)
                            && (byte_in[6:0] == 7'h00)) begin
                            emit_status = {4'h8, run_status_q[3:0]};
                        end
                    end
                    default: ;
                endcase
            end else if (byte_in < 8'hF0) begin
                run_status_d = byte_in;
                state_d      = ST_WAIT_D1;
            end else if (byte_in == 8'hF0) begin
                run_status_d = 8'h00;
                state_d      = ST_SYSEX;
            end else if (byte_in < 8'hF8) begin
                run_status_d = 8'h00;
                state_d      = ST_IDLE;
            end else begin
                // Real-time: parser context untouched
                emit        = (C_PASS_RT != 0);
                emit_status = byte_in;
                emit_len    = 2'd1;
            end
        end

        if (emit) begin
            msg_valid_d  = 1'b1;
            msg_status_d = emit_status;
            msg_data1_d  = emit_d1;
            msg_data2_d  = emit_d2;
            msg_len_d    = emit_len;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            run_status_q <= 8'h00;
            data1_q      <= 7'h00;
            msg_valid_q  <= 1'b0;
            msg_status_q <= 8'h00;
            msg_data1_q  <= 7'h00;
            msg_data2_q  <= 7'h00;
            msg_len_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            run_status_q <= run_status_d;
            data1_q      <= data1_d;
            msg_valid_q  <= msg_valid_d;
            msg_status_q <= msg_status_d;
            msg_data1_q  <= msg_data1_d;
            msg_data2_q  <= msg_data2_d;
            msg_len_q    <= msg_len_d;
        end
    end

    assign msg_valid  = msg_valid_q;
    assign msg_status = msg_status_q;
    assign msg_data1  = msg_data1_q;
    assign msg_data2  = msg_data2_q;
    assign msg_len    = msg_len_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser: an omni instance with defaults and a
// channel-2 filtered instance with real-time drop and no vel0 rewrite.
module tb_midi_msg_parser;

    logic clk = 1'b0;
    logic rst;

    logic [7:0] a_byte, f_byte;
    logic       a_valid, f_valid, a_rdy, f_rdy, a_mready, f_mready;
    logic [7:0] a_st, f_st;
    logic [6:0] a_d1, a_d2, f_d1, f_d2;
    logic [1:0] a_len, f_len;
    logic       a_mvalid, f_mvalid;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          log_en   = 1'b0;
    logic [23:0] qa[$];
    logic [23:0] qf[$];

    always #5 clk = ~clk;

    midi_msg_parser dut_a (
        .clk(clk), .rst(rst), .byte_in(a_byte), .byte_valid(a_valid), .byte_ready(a_rdy),
        .msg_status(a_st), .msg_data1(a_d1), .msg_data2(a_d2), .msg_len(a_len),
        .msg_valid(a_mvalid), .msg_ready(a_mready)
    );

    midi_msg_parser #(
        .C_CHANNEL(2), .C_OMNI(0), .C_VEL0_NOTEOFF(0), .C_PASS_RT(0)
    ) dut_f (
        .clk(clk), .rst(rst), .byte_in(f_byte), .byte_valid(f_valid), .byte_ready(f_rdy),
        .msg_status(f_st), .msg_data1(f_d1), .msg_data2(f_d2), .msg_len(f_len),
        .msg_valid(f_mvalid), .msg_ready(f_mready)
    );

    // Record every message that is handed off while logging is enabled
    always @(negedge clk) begin
        if (log_en && a_mvalid && a_mready) qa.push_back({a_st, a_d1, a_d2, a_len});
        if (log_en && f_mvalid && f_mready) qf.push_back({f_st, f_d1, f_d2, f_len});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one byte (called at a negedge), hold until accepted
    task automatic send(input bit sel, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        if (sel) begin f_byte = b; f_valid = 1'b1; end
        else     begin a_byte = b; a_valid = 1'b1; end
        for (int i = 0; i < 50; i++) begin
            if (sel ? f_rdy : a_rdy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (sel) f_valid = 1'b0;
        else     a_valid = 1'b0;
    endtask

    task automatic send_seq(input bit sel, input logic [7:0] b[]);
        foreach (b[i]) send(sel, b[i]);
        idle(2);
    endtask

    task automatic exp_msg(input bit sel, input string tag, input logic [7:0] st,
                           input logic [6:0] d1, input logic [6:0] d2, input logic [1:0] len);
        logic [23:0] got;
        got = 24'h0;
        if (sel) begin if (qf.size() > 0) got = qf.pop_front(); end
        else     begin if (qa.size() > 0) got = qa.pop_front(); end
        check(tag, 32'(got), 32'({st, d1, d2, len}));
    endtask

    task automatic exp_none(input bit sel, input string tag);
        check(tag, sel ? qf.size() : qa.size(), 32'd0);
        if (sel) qf.delete();
        else     qa.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_byte = 8'h00; a_valid = 1'b0; a_mready = 1'b1;
        f_byte = 8'h00; f_valid = 1'b0; f_mready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_valid", 32'(a_mvalid), 32'd0);
        check("rst_status", 32'(a_st), 32'h00);
        check("rst_d1", 32'(a_d1), 32'h00);
        check("rst_d2", 32'(a_d2), 32'h00);
        check("rst_len", 32'(a_len), 32'd0);
        check("rst_ready", 32'(a_rdy), 32'd1);
        log_en = 1'b1;

        // 1: full message, valid the cycle after the last handshake
        send(0, 8'h90);
        send(0, 8'h3C);
        check("t1_not_yet", 32'(a_mvalid), 32'd0);
        send(0, 8'h64);
        check("t1_latency", 32'(a_mvalid), 32'd1);
        idle(2);
        exp_msg(0, "t1_msg", 8'h90, 7'h3C, 7'h64, 2'd3);
        exp_none(0, "t1_extra");

        // 2: running status continues from test 1
        send_seq(0, '{8'h40, 8'h50});
        exp_msg(0, "t2_msg", 8'h90, 7'h40, 7'h50, 2'd3);
        exp_none(0, "t2_extra");

        // 3: one-data command with running status
        send_seq(0, '{8'hC5, 8'h07, 8'h09});
        exp_msg(0, "t3_msg0", 8'hC5, 7'h07, 7'h00, 2'd2);
        exp_msg(0, "t3_msg1", 8'hC5, 7'h09, 7'h00, 2'd2);
        exp_none(0, "t3_extra");

        // 4: zero-velocity note-on becomes note-off
        send_seq(0, '{8'h91, 8'h3C, 8'h00});
        exp_msg(0, "t4_msg", 8'h81, 7'h3C, 7'h00, 2'd3);
        exp_none(0, "t4_extra");

        // 5: real-time byte interleaved mid-message
        send_seq(0, '{8'h90, 8'h3C, 8'hF8, 8'h64});
        exp_msg(0, "t5_rt", 8'hF8, 7'h00, 7'h00, 2'd1);
        exp_msg(0, "t5_msg", 8'h90, 7'h3C, 7'h64, 2'd3);
        exp_none(0, "t5_extra");

        // 6: SysEx skipped, system common clears running status
        send_seq(0, '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C, 8'h64});
        exp_none(0, "t6_none");

        // New voice status discards a partial message
        send_seq(0, '{8'h90, 8'h3C, 8'h80, 8'h3C, 8'h40});
        exp_msg(0, "tp_msg", 8'h80, 7'h3C, 7'h40, 2'd3);
        exp_none(0, "tp_extra");

        // 7: channel filter, real-time drop and no vel0 rewrite on filtered instance
        send_seq(1, '{8'h91, 8'h3C, 8'h64, 8'h3C, 8'h64});
        exp_none(1, "t7_filtered");
        send_seq(1, '{8'h92, 8'h3C, 8'h64, 8'hF8, 8'h3C, 8'h00});
        exp_msg(1, "t7_msg", 8'h92, 7'h3C, 7'h64, 2'd3);
        exp_msg(1, "t7_vel0", 8'h92, 7'h3C, 7'h00, 2'd3);
        exp_none(1, "t7_extra");

        // 8: backpressure, then release with simultaneous retire and load
        log_en = 1'b0;
        a_mready = 1'b0;
        send(0, 8'hC5);
        send(0, 8'h07);
        check("t8_valid", 32'(a_mvalid), 32'd1);
        check("t8_rdy_low", 32'(a_rdy), 32'd0);
        a_byte = 8'h09;
        a_valid = 1'b1;
        idle(3);
        check("t8_hold_valid", 32'(a_mvalid), 32'd1);
        check("t8_hold_rdy", 32'(a_rdy), 32'd0);
        check("t8_hold_fields", 32'({a_st, a_d1, a_d2, a_len}), 32'({8'hC5, 7'h07, 7'h00, 2'd2}));
        a_mready = 1'b1;
        #1;
        check("t8_rdy_release", 32'(a_rdy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        check("t8_nobubble_valid", 32'(a_mvalid), 32'd1);
        check("t8_nobubble_fields", 32'({a_st, a_d1, a_d2, a_len}), 32'({8'hC5, 7'h09, 7'h00, 2'd2}));
        idle(1);
        check("t8_retired", 32'(a_mvalid), 32'd0);

        // Reset drops a pending output
        a_mready = 1'b0;
        send_seq(0, '{8'h90, 8'h3C, 8'h64});
        check("tr_pending", 32'(a_mvalid), 32'd1);
        pulse_reset();
        check("tr_valid", 32'(a_mvalid), 32'd0);
        check("tr_status", 32'(a_st), 32'h00);
        a_mready = 1'b1;

        // Reset mid-message loses partial message and running status
        log_en = 1'b1;
        send(0, 8'h90);
        send(0, 8'h3C);
        pulse_reset();
        send_seq(0, '{8'h64, 8'h40, 8'h50});
        exp_none(0, "tr_lost");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
